// File: rtl/mult_adder_ctrl_pkg.sv
// Shared network parameters and controller state encoding for the
// multiply-adder tree controller.
package mult_adder_ctrl_pkg;

  localparam int MA_TREE_SIZE = 16;
  localparam int MA_MULT_W    = 8;
  localparam int MA_ADD_W     = 20;
  localparam int MA_LATENCY   = 1 + $clog2(MA_TREE_SIZE);

  // One multiplier stage followed by a log2-deep adder tree.
  function automatic int ma_latency(input int tree_size);
    return 1 + $clog2(tree_size);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ma_state_t;

endpackage

// File: rtl/mult_adder_ctrl_fifo.sv
// Synchronous result FIFO with occupancy count; pointers wrap modulo DEPTH
// so non-power-of-two depths are supported.
module mult_adder_ctrl_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 21,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // A pop frees the head slot in the same cycle, so push is legal when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mult_adder_ctrl.sv
// Job controller for the multiply-adder tree: issues windows under a credit
// scheme, tracks in-flight results and buffers them for the consumer.
module mult_adder_ctrl
  import mult_adder_ctrl_pkg::*;
#(
  parameter int TREE_SIZE  = MA_TREE_SIZE,
  parameter int MULT_W     = MA_MULT_W,
  parameter int ADD_W      = MA_ADD_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 num_windows,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TREE_SIZE*MULT_W-1:0] in_data,
  input  logic [TREE_SIZE*MULT_W-1:0] in_kernel,
  output logic [TREE_SIZE*MULT_W-1:0] ma_in,
  output logic [TREE_SIZE*MULT_W-1:0] ma_kernel,
  input  logic [ADD_W-1:0]            ma_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADD_W-1:0]            out_data,
  output logic                        out_last
);

  localparam int LATENCY = ma_latency(TREE_SIZE);
  localparam int FC_W    = $clog2(FIFO_DEPTH + 1);
  localparam int CR_W    = FC_W + 1;

  ma_state_t         state;
  ma_state_t         state_next;
  logic [15:0]       num_windows_q;
  logic [15:0]       issued;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_last;
  logic [CR_W-1:0]   inflight;
  logic [CR_W-1:0]   credits;
  logic              issue;
  logic              issue_last;
  logic              pop;
  logic              push;
  logic [ADD_W:0]    fifo_head;
  logic              fifo_empty;
  logic [FC_W-1:0]   fifo_count;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + {{(CR_W-1){1'b0}}, tag_valid[i]};
    end
  end

  // Slots already promised to in-flight windows are not available.
  assign credits = CR_W'(FIFO_DEPTH) - CR_W'(fifo_count) - inflight;

  assign pop        = out_valid & out_ready;
  // A same-cycle pop releases a slot, so an issue may take it without a bubble.
  assign in_ready   = (state == ST_RUN) && (issued < num_windows_q) &&
                      ((credits != '0) || pop);
  assign issue      = in_valid & in_ready;
  assign issue_last = issue && (issued == num_windows_q - 16'd1);

  assign ma_in      = issue ? in_data   : '0;
  assign ma_kernel  = issue ? in_kernel : '0;

  assign push       = tag_valid[LATENCY-1];

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign out_valid  = ~fifo_empty;
  assign out_data   = out_valid ? fifo_head[ADD_W-1:0] : '0;
  assign out_last   = out_valid & fifo_head[ADD_W];

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = (num_windows != 16'd0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && fifo_head[ADD_W]) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Clearing the tags on reset is what keeps stale ma_out values out of the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_windows_q <= '0;
      issued        <= '0;
      tag_valid     <= '0;
      tag_last      <= '0;
    end else begin
      tag_valid <= {tag_valid[LATENCY-2:0], issue};
      tag_last  <= {tag_last[LATENCY-2:0], issue_last};
      if (state == ST_IDLE && start) begin
        num_windows_q <= num_windows;
        issued        <= '0;
      end else if (issue) begin
        issued <= issued + 16'd1;
      end
    end
  end

  mult_adder_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADD_W + 1),
    .CNT_W (FC_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({tag_last[LATENCY-1], ma_out}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mult_adder_ctrl.sv
// Scoreboard bench for mult_adder_ctrl with a behavioural multiply-adder
// datapath and randomized jobs.
module tb_mult_adder_ctrl;

  localparam int TS  = 16;
  localparam int MW  = 8;
  localparam int AW  = 20;
  localparam int LAT = 5;
  localparam int DW  = TS * MW;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   num_windows;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] in_kernel;
  logic [DW-1:0] ma_in;
  logic [DW-1:0] ma_kernel;
  logic [AW-1:0] ma_out;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          out_last;

  typedef struct packed {
    logic          last;
    logic [AW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   job_nw = 0;
  int   job_issued = 0;
  int   stalls = 0;
  int   or_mode = 1;
  logic [AW-1:0] pipe [LAT];

  mult_adder_ctrl #(
    .TREE_SIZE  (TS),
    .MULT_W     (MW),
    .ADD_W      (AW),
    .FIFO_DEPTH (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_windows (num_windows),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_kernel   (in_kernel),
    .ma_in       (ma_in),
    .ma_kernel   (ma_kernel),
    .ma_out      (ma_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] ref_sum(input logic [DW-1:0] d, input logic [DW-1:0] k);
    int unsigned s = 0;
    int unsigned a;
    int unsigned b;
    for (int i = 0; i < TS; i++) begin
      a = int'(d[i*MW +: MW]);
      b = int'(k[i*MW +: MW]);
      s = s + a * b;
    end
    return s[AW-1:0];
  endfunction

  // External multiply-adder datapath: LAT edges from ma_in to ma_out.
  always @(posedge clock) begin
    pipe[0] <= ref_sum(ma_in, ma_kernel);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ma_out = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every accepted result.
  logic          stall_prev = 1'b0;
  logic [AW-1:0] prev_data;
  logic          prev_last;
  exp_t          e;
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (!(in_valid && in_ready))
        chk("ma_idle_zero", 32'(ma_in != '0 || ma_kernel != '0), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_data), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic start_job(input int nw);
    start       = 1'b1;
    num_windows = 16'(nw);
    @(posedge clock);
    #1;
    start      = 1'b0;
    job_nw     = nw;
    job_issued = 0;
  endtask

  task automatic drive_cycle(input bit alw, input bit fixed, input bit poke);
    if (fixed) begin
      in_data   = {TS{8'd1}};
      in_kernel = {TS{8'd2}};
    end else begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_kernel = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = (job_issued < job_nw) && (alw || $urandom_range(0, 3) != 0);
    start    = poke;
    if (poke) num_windows = 16'd7;
    @(negedge clock);
    if (in_valid && in_ready) begin
      job_issued++;
      exp_q.push_back('{last: (job_issued == job_nw), data: ref_sum(in_data, in_kernel)});
    end else if (in_valid) begin
      stalls++;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_issue(input int maxc, input bit alw, input bit fixed);
    int n = 0;
    while (job_issued < job_nw && n < maxc) begin
      drive_cycle(alw, fixed, 1'b0);
      n++;
    end
    in_valid = 1'b0;
    chk("issue_count", 32'(job_issued), 32'(job_nw));
  endtask

  task automatic wait_done();
    int n = 0;
    bit got = 0;
    while (!got && n < 300) begin
      @(negedge clock);
      n++;
      if (done) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ma_zero"}, 32'(ma_in != '0 || ma_kernel != '0), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
  endtask

  int seen;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    num_windows = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_kernel   = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single window: every lane 1*2, sixteen lanes.
    or_mode = 1;
    start_job(1);
    run_issue(50, 1'b1, 1'b1);
    wait_done();

    // Streaming with both sides always ready.
    stalls = 0;
    start_job(20);
    run_issue(100, 1'b1, 1'b0);
    chk("stream_stalls", 32'(stalls), 32'd0);
    wait_done();

    // Backpressure: the buffer bounds issues, then the rest drain through.
    or_mode = 0;
    start_job(12);
    repeat (30) drive_cycle(1'b1, 1'b0, 1'b0);
    chk("bp_issued", 32'(job_issued), 32'd8);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    or_mode = 1;
    run_issue(100, 1'b1, 1'b0);
    wait_done();

    // Empty job goes straight to DONE.
    start_job(0);
    @(negedge clock);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_in_ready", 32'(in_ready), 32'd0);
    chk("zero_out_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    chk("zero_done_end", 32'(done), 32'd0);
    chk("zero_busy_end", 32'(busy), 32'd0);
    @(posedge clock);
    #1;

    // start while running must not restart or resize the job.
    or_mode = 2;
    start_job(4);
    drive_cycle(1'b0, 1'b0, 1'b1);
    run_issue(200, 1'b0, 1'b0);
    wait_done();

    // Reset with three windows in flight.
    or_mode = 0;
    start_job(10);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    chk("rst_issued", 32'(job_issued), 32'd3);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clock);
    #1;
    reset   = 1'b0;
    or_mode = 1;
    seen    = 0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("rst_no_stale_out", 32'(seen), 32'd0);
    @(posedge clock);
    #1;
    start_job(2);
    run_issue(50, 1'b1, 1'b0);
    wait_done();

    // Randomized jobs with random valid and ready.
    repeat (6) begin
      or_mode = 2;
      start_job(int'($urandom_range(1, 25)));
      run_issue(400, 1'b0, 1'b0);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
